fifo_ctrl: RTL and testbench

Pointer and flag controller for the 8-entry FIFO storage array. It accepts push/pop requests from the producer and consumer and drives the storage array's write, read, write_addr, read_addr, fifo_full and fifo_empty inputs. It also produces occupancy, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a read-data-valid strobe that matches the array's one-cycle registered read.

---
 rtl/fifo_ctrl.sv | 92 +++++++++
 tb/tb_fifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a 2**n-entry FIFO storage array.
// Wrap-bit pointers give full/empty/count combinationally; errors are sticky.
module fifo_ctrl #(
    parameter int n        = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clr_err,
    output logic         write,
    output logic         read,
    output logic [n-1:0] write_addr,
    output logic [n-1:0] read_addr,
    output logic         fifo_full,
    output logic         fifo_empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [n:0]   count,
    output logic         overflow,
    output logic         underflow,
    output logic         rd_valid
);

    localparam logic [n:0] AF_CNT = (n+1)'(AF_LEVEL);
    localparam logic [n:0] AE_CNT = (n+1)'(AE_LEVEL);

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    logic [n:0] wr_ptr;
    logic [n:0] rd_ptr;

    // Status flags and strobes decoded from the registered pointers.
    always_comb begin
        fifo_empty   = (wr_ptr == rd_ptr);
        fifo_full    = (wr_ptr[n-1:0] == rd_ptr[n-1:0])
                    && (wr_ptr[n] != rd_ptr[n]);
        count        = wr_ptr - rd_ptr;
        almost_full  = (count >= AF_CNT);
        almost_empty = (count <= AE_CNT);
        write        = push & ~fifo_full;
        read         = pop & ~fifo_empty;
        write_addr   = wr_ptr[n-1:0];
        read_addr    = rd_ptr[n-1:0];
    end

    // Write pointer advances on every accepted write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wr_ptr <= '0;
        else if (write)
            wr_ptr <= wr_ptr + 1'b1;
    end

    // Read pointer advances on every accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_ptr <= '0;
        else if (read)
            rd_ptr <= rd_ptr + 1'b1;
    end

    // Sticky overflow; a new error event beats a coincident clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overflow <= 1'b0;
        else if (push && fifo_full)
            overflow <= 1'b1;
        else if (clr_err)
            overflow <= 1'b0;
    end

    // Sticky underflow; a new error event beats a coincident clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            underflow <= 1'b0;
        else if (pop && fifo_empty)
            underflow <= 1'b1;
        else if (clr_err)
            underflow <= 1'b0;
    end

    // rd_valid marks the cycle the storage's registered data_out is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_valid <= 1'b0;
        else
            rd_valid <= read;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: table vectors, directed corner sequences and random
// traffic checked against a queue-based FIFO occupancy model.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, clr_err;
    logic       write, read;
    logic [2:0] write_addr, read_addr;
    logic       fifo_full, fifo_empty;
    logic       almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow, rd_valid;

    int checks = 0;
    int failures = 0;

    fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .push(push), .pop(pop), .clr_err(clr_err),
        .write(write), .read(read),
        .write_addr(write_addr), .read_addr(read_addr),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow), .underflow(underflow),
        .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: queue of stored items plus lifetime push/pop totals.
    int q[$];
    int wr_total, rd_total;
    bit m_ov, m_un, m_rv;

    task automatic model_clear();
        q.delete();
        wr_total = 0;
        rd_total = 0;
        m_ov = 0;
        m_un = 0;
        m_rv = 0;
    endtask

    task automatic check_vs_model(string tag, bit p, bit pp);
        int sz;
        sz = q.size();
        chk({tag, "_count"}, int'(count), sz);
        chk({tag, "_full"}, int'(fifo_full), int'(sz == 8));
        chk({tag, "_empty"}, int'(fifo_empty), int'(sz == 0));
        chk({tag, "_af"}, int'(almost_full), int'(sz >= 6));
        chk({tag, "_ae"}, int'(almost_empty), int'(sz <= 2));
        chk({tag, "_waddr"}, int'(write_addr), wr_total % 8);
        chk({tag, "_raddr"}, int'(read_addr), rd_total % 8);
        chk({tag, "_write"}, int'(write), int'(p && sz < 8));
        chk({tag, "_read"}, int'(read), int'(pp && sz > 0));
        chk({tag, "_ovf"}, int'(overflow), int'(m_ov));
        chk({tag, "_unf"}, int'(underflow), int'(m_un));
        chk({tag, "_rdv"}, int'(rd_valid), int'(m_rv));
    endtask

    // One clock cycle: drive, check pre-edge state, advance model, clock.
    task automatic do_cycle(string tag, bit p, bit pp, bit c);
        int  sz;
        bit  w, r;
        push    = p;
        pop     = pp;
        clr_err = c;
        #1;
        check_vs_model(tag, p, pp);
        sz = q.size();
        w  = p && sz < 8;
        r  = pp && sz > 0;
        if (p && sz == 8) m_ov = 1;
        else if (c)       m_ov = 0;
        if (pp && sz == 0) m_un = 1;
        else if (c)        m_un = 0;
        if (r) begin
            void'(q.pop_front());
            rd_total++;
        end
        if (w) begin
            q.push_back(wr_total);
            wr_total++;
        end
        m_rv = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push    = 0;
        pop     = 0;
        clr_err = 0;
        rst     = 0;
        #1;
        model_clear();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit push, pop, clr;
        bit ew, er;
        int cnt;
        bit ov, un, rv;
        int wa, ra;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit p, bit pp, bit c, bit ew, bit er,
                                int cnt, bit ov, bit un, bit rv,
                                int wa, int ra);
        vec_t v;
        v.push = p;  v.pop = pp; v.clr = c;
        v.ew = ew;   v.er = er;  v.cnt = cnt;
        v.ov = ov;   v.un = un;  v.rv = rv;
        v.wa = wa;   v.ra = ra;
        tbl.push_back(v);
    endfunction

    initial begin
        bit  saw_wrap;
        int  prev_wa;
        bit  p, pp, c;
        int  bias;

        rst = 0;
        push = 0;
        pop = 0;
        clr_err = 0;
        model_clear();

        // Reset values while rst is held low.
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_full", int'(fifo_full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_unf", int'(underflow), 0);
        chk("rst_rdv", int'(rd_valid), 0);
        chk("rst_waddr", int'(write_addr), 0);
        chk("rst_raddr", int'(read_addr), 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;

        // Fill, overflow, clear, drain, underflow, simultaneous ops.
        for (int i = 1; i <= 8; i++)
            add(1, 0, 0, 1, 0, i, 0, 0, 0, i % 8, 0);
        add(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 8, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 0, 1, 8 - k, 0, 0, 1, 0, k % 8);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        for (int j = 1; j <= 7; j++)
            add(1, 0, 0, 1, 0, 1 + j, 0, 0, 0, (1 + j) % 8, 0);
        add(1, 1, 0, 0, 1, 7, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            push    = tbl[i].push;
            pop     = tbl[i].pop;
            clr_err = tbl[i].clr;
            #1;
            chk($sformatf("v%0d_write", i), int'(write), int'(tbl[i].ew));
            chk($sformatf("v%0d_read", i), int'(read), int'(tbl[i].er));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("v%0d_full", i), int'(fifo_full),
                int'(tbl[i].cnt == 8));
            chk($sformatf("v%0d_empty", i), int'(fifo_empty),
                int'(tbl[i].cnt == 0));
            chk($sformatf("v%0d_af", i), int'(almost_full),
                int'(tbl[i].cnt >= 6));
            chk($sformatf("v%0d_ae", i), int'(almost_empty),
                int'(tbl[i].cnt <= 2));
            chk($sformatf("v%0d_ovf", i), int'(overflow), int'(tbl[i].ov));
            chk($sformatf("v%0d_unf", i), int'(underflow), int'(tbl[i].un));
            chk($sformatf("v%0d_rdv", i), int'(rd_valid), int'(tbl[i].rv));
            chk($sformatf("v%0d_waddr", i), int'(write_addr), tbl[i].wa);
            chk($sformatf("v%0d_raddr", i), int'(read_addr), tbl[i].ra);
        end

        // Wrap-around with occupancy held at 3.
        do_reset();
        for (int i = 0; i < 3; i++)
            do_cycle("wfill", 1, 0, 0);
        saw_wrap = 0;
        prev_wa  = int'(write_addr);
        for (int i = 0; i < 20; i++) begin
            do_cycle("wrap", 1, 1, 0);
            chk("wrap_count3", int'(count), 3);
            if (prev_wa == 7 && write_addr == 3'd0)
                saw_wrap = 1;
            prev_wa = int'(write_addr);
        end
        chk("wrap_seen", int'(saw_wrap), 1);
        do_cycle("wrap_end", 0, 0, 0);

        // Asynchronous reset between edges with count=5 and read active.
        do_reset();
        for (int i = 0; i < 5; i++)
            do_cycle("mfill", 1, 0, 0);
        push = 0;
        pop  = 1;
        #1;
        chk("mid_read_pre", int'(read), 1);
        chk("mid_count_pre", int'(count), 5);
        #1;
        rst = 0;
        #1;
        chk("mid_count", int'(count), 0);
        chk("mid_empty", int'(fifo_empty), 1);
        chk("mid_full", int'(fifo_full), 0);
        chk("mid_ae", int'(almost_empty), 1);
        chk("mid_af", int'(almost_full), 0);
        chk("mid_rdv", int'(rd_valid), 0);
        chk("mid_read", int'(read), 0);
        chk("mid_waddr", int'(write_addr), 0);
        chk("mid_raddr", int'(read_addr), 0);
        chk("mid_ovf", int'(overflow), 0);
        chk("mid_unf", int'(underflow), 0);
        @(posedge clk);
        @(negedge clk);
        pop = 0;
        rst = 1;
        model_clear();
        @(posedge clk);
        #1;
        do_cycle("post_rst", 0, 0, 0);
        do_cycle("post_rst", 0, 0, 0);

        // Random traffic with drifting push/pop bias.
        do_reset();
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0)
                bias = int'($urandom_range(15, 85));
            p  = ($urandom_range(99, 0) < bias);
            pp = ($urandom_range(99, 0) >= bias - 10);
            c  = ($urandom_range(15, 0) == 0);
            do_cycle("rnd", p, pp, c);
        end
        do_cycle("rnd_end", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
